// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Instruction handshake bundle between an instruction source and the
//   ALU issue controller.
//   master : drives instr_valid/op/rd/rs1/rs2/use_c, samples instr_ready
//   slave  : samples the instruction fields, drives instr_ready
interface alu_issue_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs1;
  logic [1:0] instr_rs2;
  logic       instr_use_c;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_use_c,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_use_c,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequencer in front of a combinational 4-bit ALU. Holds a 4x4 register
//   file, accepts one reg-reg instruction per 3 cycles (IDLE->EXEC->WB),
//   drives the ALU from registered operands, captures Y/CarryOUT/overflow,
//   writes back and maintains C/V/Z/N.
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   instr (slave)       : instruction valid/ready handshake + fields
//   ld_en/addr/data     : direct register load (honoured in IDLE only)
//   dbg_addr/dbg_data   : combinational register file read
//   alu_*  (out)        : ALU operand / carry / opcode drive (registered)
//   alu_y/carry_out/overflow (in) : ALU results
//   done, done_err      : one-cycle retire pulse (high during WB)
//   result              : last retired value
//   flag_c/v/z/n        : status flags
// Register file, flags and result commit on the clock edge that ends WB,
// so they are visible from the cycle after the done pulse onward.
module alu_issue_ctrl #(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  instr,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [W-1:0]     ld_data,
  input  logic [1:0]       dbg_addr,
  output logic [W-1:0]     dbg_data,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_carry_in,
  output logic             alu_op_a,
  output logic             alu_op_b,
  output logic             alu_op_c,
  input  logic [W-1:0]     alu_y,
  input  logic             alu_carry_out,
  input  logic             alu_overflow,
  output logic             done,
  output logic             done_err,
  output logic [W-1:0]     result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]            r_state;
  logic [NREG-1:0][W-1:0] r_regs;
  logic [1:0]            r_rd;
  logic                  r_illegal;
  logic                  r_arith;     // ADD/SUB: updates C and V
  logic [W-1:0]          r_alu_a, r_alu_b;
  logic                  r_alu_cin;
  logic [2:0]            r_alu_op;
  logic [W-1:0]          r_cap_y;
  logic                  r_cap_c, r_cap_v;
  logic                  r_done, r_done_err;
  logic [W-1:0]          r_result;
  logic                  r_c, r_v, r_z, r_n;
  logic                  w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (instr.instr_op)
      3'd0, 3'd1, 3'd4, 3'd5, 3'd6: w_legal = 1'b1;
      default:                      w_legal = 1'b0;
    endcase
  end

  assign instr.instr_ready = (r_state == S_IDLE);
  assign dbg_data          = r_regs[dbg_addr];
  assign alu_a             = r_alu_a;
  assign alu_b             = r_alu_b;
  assign alu_carry_in      = r_alu_cin;
  assign {alu_op_a, alu_op_b, alu_op_c} = r_alu_op;
  assign done              = r_done;
  assign done_err          = r_done_err;
  assign result            = r_result;
  assign flag_c            = r_c;
  assign flag_v            = r_v;
  assign flag_z            = r_z;
  assign flag_n            = r_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_regs     <= '0;
      r_rd       <= '0;
      r_illegal  <= 1'b0;
      r_arith    <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_cin  <= 1'b0;
      r_alu_op   <= '0;
      r_cap_y    <= '0;
      r_cap_c    <= 1'b0;
      r_cap_v    <= 1'b0;
      r_done     <= 1'b0;
      r_done_err <= 1'b0;
      r_result   <= '0;
      r_c        <= 1'b0;
      r_v        <= 1'b0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_en) r_regs[ld_addr] <= ld_data;
          if (instr.instr_valid) begin
            // Operands come from pre-edge register values, so a same-cycle
            // load or a later write to rd cannot disturb this instruction.
            r_state   <= S_EXEC;
            r_rd      <= instr.instr_rd;
            r_illegal <= !w_legal;
            r_arith   <= !instr.instr_op[2];
            if (w_legal) begin
              r_alu_a   <= r_regs[instr.instr_rs1];
              r_alu_b   <= r_regs[instr.instr_rs2];
              r_alu_cin <= instr.instr_use_c & r_c;
              r_alu_op  <= instr.instr_op;
            end
          end
        end
        S_EXEC: begin
          r_cap_y    <= alu_y;
          r_cap_c    <= alu_carry_out;
          r_cap_v    <= alu_overflow;
          r_alu_a    <= '0;
          r_alu_b    <= '0;
          r_alu_cin  <= 1'b0;
          r_alu_op   <= '0;
          r_done     <= 1'b1;
          r_done_err <= r_illegal;
          r_state    <= S_WB;
        end
        S_WB: begin
          r_done     <= 1'b0;
          r_done_err <= 1'b0;
          r_state    <= S_IDLE;
          if (!r_illegal) begin
            r_regs[r_rd] <= r_cap_y;
            r_result     <= r_cap_y;
            r_z          <= (r_cap_y == '0);
            r_n          <= r_cap_y[W-1];
            if (r_arith) begin
              r_c <= r_cap_c;
              r_v <= r_cap_v;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [1:0] ld_addr, dbg_addr;
  logic [3:0] ld_data, dbg_data, alu_a, alu_b, alu_y, result;
  logic       alu_carry_in, alu_op_a, alu_op_b, alu_op_c;
  logic       alu_carry_out, alu_overflow;
  logic       done, done_err, flag_c, flag_v, flag_z, flag_n;

  int checks = 0;
  int errors = 0;

  // reference architectural state
  logic [3:0] m_regs [4];
  logic       m_c, m_v, m_z, m_n;
  logic [3:0] m_res;

  alu_issue_ctrl_if ifc();

  alu_issue_ctrl #(.NREG(4), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(ifc),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_c(alu_op_c),
    .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .done(done), .done_err(done_err), .result(result),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: returns {carry_out, overflow, y}
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    int s;
    logic [3:0] y;
    logic co, ov;
    co = 1'b0; ov = 1'b0; y = 4'h0;
    case (op)
      3'd0: begin
        s  = int'(a) + int'(b) + int'(cin);
        y  = 4'(s);
        co = (s > 15);
        ov = (a[3] == b[3]) && (y[3] != a[3]);
      end
      3'd1: begin
        s  = int'(a) - int'(b) - int'(cin);
        y  = 4'(s);
        co = (s < 0);
        ov = (a[3] != b[3]) && (y[3] != a[3]);
      end
      3'd4: y = a & b;
      3'd5: y = a | b;
      3'd6: y = a ^ b;
      default: begin y = 4'h5; co = 1'b1; ov = 1'b1; end
    endcase
    return {co, ov, y};
  endfunction

  always_comb {alu_carry_out, alu_overflow, alu_y} = alu_fn({alu_op_a, alu_op_b, alu_op_c},
                                                            alu_a, alu_b, alu_carry_in);

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    {m_c, m_v, m_z, m_n} = 4'b0;
    m_res = 4'h0;
  endtask

  // compare register file (via debug port), flags and result to the model
  task automatic check_arch_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checks++;
      if (dbg_data !== m_regs[i]) begin
        errors++;
        $display("FAIL %s reg%0d: got %h exp %h", tag, i, dbg_data, m_regs[i]);
      end
    end
    checks++;
    if ({flag_c, flag_v, flag_z, flag_n} !== {m_c, m_v, m_z, m_n}) begin
      errors++;
      $display("FAIL %s flags CVZN: got %b exp %b", tag,
               {flag_c, flag_v, flag_z, flag_n}, {m_c, m_v, m_z, m_n});
    end
    checks++;
    if (result !== m_res) begin
      errors++;
      $display("FAIL %s result: got %h exp %h", tag, result, m_res);
    end
  endtask

  task automatic do_ld(input logic [1:0] addr, input logic [3:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_regs[addr] = data;
  endtask

  // Issue one instruction and walk it through EXEC and WB, checking each phase.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic uc, input logic hold,
                       input logic ld_exec, input string tag);
    logic       legal;
    logic [3:0] ea, eb;
    logic       ecin;
    logic [5:0] r;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
    ea   = legal ? m_regs[rs1] : 4'h0;
    eb   = legal ? m_regs[rs2] : 4'h0;
    ecin = legal ? (uc & m_c) : 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_idle: got %b exp 1", tag, ifc.instr_ready);
    end
    ifc.instr_valid = 1'b1; ifc.instr_op = op; ifc.instr_rd = rd;
    ifc.instr_rs1 = rs1; ifc.instr_rs2 = rs2; ifc.instr_use_c = uc;
    @(posedge clk); #1;  // EXEC
    if (!hold) ifc.instr_valid = 1'b0;
    checks++;
    if ({ifc.instr_ready, done, alu_a, alu_b, alu_carry_in, alu_op_a, alu_op_b, alu_op_c} !==
        {1'b0, 1'b0, ea, eb, ecin, (legal ? op : 3'd0)}) begin
      errors++;
      $display("FAIL %s exec_drive rdy/done/a/b/cin/op: got %b %b %h %h %b %b%b%b exp 0 0 %h %h %b %b",
               tag, ifc.instr_ready, done, alu_a, alu_b, alu_carry_in, alu_op_a, alu_op_b,
               alu_op_c, ea, eb, ecin, (legal ? op : 3'd0));
    end
    if (ld_exec) begin
      ld_en = 1'b1; ld_addr = rs1; ld_data = ~m_regs[rs1];
    end
    @(posedge clk); #1;  // WB
    ld_en = 1'b0;
    checks++;
    if ({done, done_err, ifc.instr_ready, alu_a, alu_b, alu_carry_in} !==
        {1'b1, !legal, 1'b0, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL %s wb done/err/rdy/a/b/cin: got %b %b %b %h %h %b exp 1 %b 0 0 0 0",
               tag, done, done_err, ifc.instr_ready, alu_a, alu_b, alu_carry_in, !legal);
    end
    if (legal) begin
      r = alu_fn(op, m_regs[rs1], m_regs[rs2], uc & m_c);
      m_regs[rd] = r[3:0];
      m_res = r[3:0];
      m_z = (r[3:0] == 4'h0);
      m_n = r[3];
      if (op == 3'd0 || op == 3'd1) begin
        m_c = r[5];
        m_v = r[4];
      end
    end
    @(posedge clk); #1;  // back in IDLE
    ifc.instr_valid = 1'b0;
    checks++;
    if ({done, done_err, ifc.instr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL %s post_wb done/err/rdy: got %b%b%b exp 001", tag, done, done_err,
               ifc.instr_ready);
    end
    check_arch_state(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset done: got %b exp 0", done);
      end
    end
    rst_n = 1'b1;
    model_reset();
    checks++;
    if ({ifc.instr_ready, alu_a, alu_b, alu_carry_in, alu_op_a, alu_op_b, alu_op_c, done_err} !==
        {1'b1, 4'h0, 4'h0, 1'b0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL reset outputs rdy/a/b/cin/op/err: got %b %h %h %b %b%b%b %b",
               ifc.instr_ready, alu_a, alu_b, alu_carry_in, alu_op_a, alu_op_b, alu_op_c, done_err);
    end
    check_arch_state("reset");
  endtask

  task automatic test_add_basic();
    do_ld(2'd0, 4'h3);
    do_ld(2'd1, 4'h5);
    issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, "add_basic");
  endtask

  task automatic test_carry_chain();
    do_ld(2'd0, 4'hF);
    do_ld(2'd1, 4'h1);
    issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, "add_carry");
    issue(3'd0, 2'd3, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, "adc_chain");
    issue(3'd1, 2'd3, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, "sbc_chain");
  endtask

  task automatic test_logic();
    do_ld(2'd0, 4'hA);
    do_ld(2'd1, 4'hC);
    issue(3'd4, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, "and");
    issue(3'd5, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, "or");
    issue(3'd6, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, "xor_rd_eq_rs1");
  endtask

  task automatic test_illegal();
    issue(3'd7, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0, "illegal7");
    issue(3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, "illegal2");
  endtask

  task automatic test_ld_in_exec();
    issue(3'd0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, "ld_in_exec");
  endtask

  task automatic test_back_to_back_hold();
    issue(3'd1, 2'd2, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, "hold_valid");
    @(posedge clk); #1;
    checks++;
    if ({ifc.instr_ready, done} !== 2'b10) begin
      errors++;
      $display("FAIL hold_valid no_reaccept rdy/done: got %b%b exp 10", ifc.instr_ready, done);
    end
  endtask

  task automatic test_reset_mid_exec();
    do_ld(2'd0, 4'h7);
    do_ld(2'd1, 4'h2);
    @(negedge clk);
    ifc.instr_valid = 1'b1; ifc.instr_op = 3'd0; ifc.instr_rd = 2'd2;
    ifc.instr_rs1 = 2'd0; ifc.instr_rs2 = 2'd1; ifc.instr_use_c = 1'b0;
    @(posedge clk); #1;  // EXEC
    ifc.instr_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    checks++;
    if ({done, ifc.instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid done/rdy: got %b%b exp 01", done, ifc.instr_ready);
    end
    check_arch_state("rst_mid");
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid late_done: got %b exp 0", done);
    end
  endtask

  task automatic test_random();
    logic [2:0] ops [8];
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4; ops[3] = 3'd5;
    ops[4] = 3'd6; ops[5] = 3'd0; ops[6] = 3'd1; ops[7] = 3'd7;
    for (int i = 0; i < 4; i++) do_ld(2'(i), 4'($urandom));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) do_ld(2'($urandom), 4'($urandom));
      issue(ops[$urandom_range(0, 7)], 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 1'b0, 1'($urandom_range(0, 4) == 0), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    ifc.instr_valid = 1'b0; ifc.instr_op = '0; ifc.instr_rd = '0;
    ifc.instr_rs1 = '0; ifc.instr_rs2 = '0; ifc.instr_use_c = 1'b0;
    model_reset();
    test_reset();
    test_add_basic();
    test_carry_chain();
    test_logic();
    test_illegal();
    test_ld_in_exec();
    test_back_to_back_hold();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
